// File: rtl/bitcoin_host_pkg.sv
// Shared types and default constants for the bitcoin2 host controller.
//   host_state_t   : controller FSM states
//   *_DEF          : default header/result placement and sizing
package bitcoin_host_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_START   = 3'd2,
    S_RUN     = 3'd3,
    S_RDREQ   = 3'd4,
    S_PRESENT = 3'd5
  } host_state_t;

  localparam int MSG_ADDR_DEF   = 0;
  localparam int OUT_ADDR_DEF   = 1000;
  localparam int HDR_WORDS_DEF  = 19;
  localparam int NUM_NONCES_DEF = 16;
  localparam int DEPTH_DEF      = 16384;

endpackage

// File: rtl/bitcoin_host_ctrl_if.sv
// Bundle of the host header/result streams, the co-processor start/done
// handshake and the co-processor memory port.
//   slave  : the controller side (bitcoin_host_ctrl)
//   master : the environment side (host link + co-processor)
interface bitcoin_host_ctrl_if;

  logic        hdr_valid;
  logic [31:0] hdr_data;
  logic        hdr_ready;

  logic        res_valid;
  logic [31:0] res_data;
  logic        res_last;
  logic        res_ready;

  logic        start;
  logic        done;
  logic [15:0] message_addr;
  logic [15:0] output_addr;

  logic        mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;

  logic        busy;
  logic [31:0] cycles;

  modport slave (
    input  hdr_valid, hdr_data, res_ready, done, mem_we, mem_addr, mem_write_data,
    output hdr_ready, res_valid, res_data, res_last, start, message_addr, output_addr,
           mem_read_data, busy, cycles
  );

  modport master (
    output hdr_valid, hdr_data, res_ready, done, mem_we, mem_addr, mem_write_data,
    input  hdr_ready, res_valid, res_data, res_last, start, message_addr, output_addr,
           mem_read_data, busy, cycles
  );

endinterface

// File: rtl/hash_sram.sv
// Single-port DEPTH x 32 word RAM, synchronous write, registered read.
//   clk, reset_n : clock, async active-low reset (read register only)
//   we, wdata    : write strobe and data
//   re           : read strobe; rdata updates on the next edge, else holds
//   addr         : word index
//   rdata        : registered read data
module hash_sram
  import bitcoin_host_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  // Array kept free of reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/bitcoin_host_ctrl.sv
// Host-side controller and memory responder for the bitcoin2 co-processor.
// Loads the block header into the shared RAM, pulses start, serves the
// co-processor memory port while it runs, times the run, and streams the
// result words back to the host.
//   clk, reset_n : clock, async active-low reset
//   bus (slave)  : header stream, result stream, start/done, memory port,
//                  busy and cycles status
module bitcoin_host_ctrl
  import bitcoin_host_pkg::*;
#(
  parameter int HDR_WORDS  = HDR_WORDS_DEF,
  parameter int NUM_NONCES = NUM_NONCES_DEF,
  parameter int MSG_ADDR   = MSG_ADDR_DEF,
  parameter int OUT_ADDR   = OUT_ADDR_DEF,
  parameter int DEPTH      = DEPTH_DEF
) (
  input  logic               clk,
  input  logic               reset_n,
  bitcoin_host_ctrl_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(HDR_WORDS + 1);
  localparam int IW = (NUM_NONCES > 1) ? $clog2(NUM_NONCES) : 1;

  localparam logic [CW-1:0] LAST_WORD = CW'(HDR_WORDS - 1);
  localparam logic [IW-1:0] LAST_RES  = IW'(NUM_NONCES - 1);
  localparam logic [AW-1:0] MSG_BASE  = AW'(MSG_ADDR);
  localparam logic [AW-1:0] OUT_BASE  = AW'(OUT_ADDR);

  host_state_t   state_reg, state_next;
  logic [CW-1:0] word_cnt_reg, word_cnt_next;
  logic [IW-1:0] res_idx_reg, res_idx_next;
  logic          start_cnt_reg, start_cnt_next;
  logic          hdr_ready_reg;
  logic [31:0]   cycles_reg;
  logic          co_sel_reg;
  logic [31:0]   co_hold_reg;

  logic          hdr_fire;
  logic          ram_we, ram_re, host_rd, co_rd;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_wdata, ram_rdata;

  // Only the low AW address bits select a RAM word; the rest wrap away.
  generate
    if (AW < 16) begin : g_addr_wrap
      logic unused_addr_hi;
      assign unused_addr_hi = ^bus.mem_addr[15:AW];
    end
  endgenerate

  hash_sram #(.DEPTH(DEPTH), .AW(AW)) u_sram (
    .clk     (clk),
    .reset_n (reset_n),
    .we      (ram_we),
    .re      (ram_re),
    .addr    (ram_addr),
    .wdata   (ram_wdata),
    .rdata   (ram_rdata)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= S_IDLE;
      word_cnt_reg  <= '0;
      res_idx_reg   <= '0;
      start_cnt_reg <= 1'b0;
      hdr_ready_reg <= 1'b0;
      cycles_reg    <= '0;
      co_sel_reg    <= 1'b0;
      co_hold_reg   <= '0;
    end else begin
      state_reg     <= state_next;
      word_cnt_reg  <= word_cnt_next;
      res_idx_reg   <= res_idx_next;
      start_cnt_reg <= start_cnt_next;
      // Registered so hdr_ready stays low during reset and rises on the
      // first edge after release.
      hdr_ready_reg <= (state_next == S_IDLE) || (state_next == S_LOAD);

      if ((state_next == S_START) && (state_reg != S_START)) begin
        cycles_reg <= '0;
      end else if (((state_reg == S_START) || (state_reg == S_RUN)) && (cycles_reg != '1)) begin
        cycles_reg <= cycles_reg + 32'd1;
      end

      // The RAM read register is shared with the result path. co_hold_reg
      // remembers the last co-processor read so mem_read_data does not
      // change when the controller reads results.
      if (co_sel_reg) begin
        co_hold_reg <= ram_rdata;
      end
      if (host_rd) begin
        co_sel_reg <= 1'b0;
      end else if (co_rd) begin
        co_sel_reg <= 1'b1;
      end
    end
  end

  always_comb begin
    state_next     = state_reg;
    word_cnt_next  = word_cnt_reg;
    res_idx_next   = res_idx_reg;
    start_cnt_next = start_cnt_reg;
    ram_we         = 1'b0;
    ram_re         = 1'b0;
    host_rd        = 1'b0;
    co_rd          = 1'b0;
    ram_addr       = MSG_BASE + AW'(word_cnt_reg);
    ram_wdata      = bus.hdr_data;
    hdr_fire       = hdr_ready_reg && bus.hdr_valid;

    case (state_reg)
      S_IDLE: begin
        if (hdr_fire) begin
          ram_we        = 1'b1;
          ram_addr      = MSG_BASE;
          word_cnt_next = CW'(1);
          state_next    = S_LOAD;
        end
      end
      S_LOAD: begin
        if (hdr_fire) begin
          ram_we        = 1'b1;
          word_cnt_next = word_cnt_reg + 1'b1;
          if (word_cnt_reg == LAST_WORD) begin
            start_cnt_next = 1'b0;
            state_next     = S_START;
          end
        end
      end
      S_START: begin
        start_cnt_next = 1'b1;
        if (start_cnt_reg) begin
          state_next = S_RUN;
        end
      end
      S_RUN: begin
        ram_addr  = AW'(bus.mem_addr);
        ram_wdata = bus.mem_write_data;
        ram_we    = bus.mem_we;
        ram_re    = !bus.mem_we;
        co_rd     = !bus.mem_we;
        if (bus.done) begin
          res_idx_next = '0;
          state_next   = S_RDREQ;
        end
      end
      S_RDREQ: begin
        ram_addr   = OUT_BASE + AW'(res_idx_reg);
        ram_re     = 1'b1;
        host_rd    = 1'b1;
        state_next = S_PRESENT;
      end
      S_PRESENT: begin
        if (bus.res_ready) begin
          if (res_idx_reg == LAST_RES) begin
            state_next = S_IDLE;
          end else begin
            res_idx_next = res_idx_reg + 1'b1;
            state_next   = S_RDREQ;
          end
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // No RAM reads happen in PRESENT, so the read register holds the
  // result word steady through any res_ready stall.
  assign bus.hdr_ready     = hdr_ready_reg;
  assign bus.res_valid     = (state_reg == S_PRESENT);
  assign bus.res_data      = (state_reg == S_PRESENT) ? ram_rdata : 32'd0;
  assign bus.res_last      = (state_reg == S_PRESENT) && (res_idx_reg == LAST_RES);
  assign bus.start         = (state_reg == S_START);
  assign bus.busy          = (state_reg != S_IDLE);
  assign bus.cycles        = cycles_reg;
  assign bus.message_addr  = 16'(MSG_ADDR);
  assign bus.output_addr   = 16'(OUT_ADDR);
  assign bus.mem_read_data = co_sel_reg ? ram_rdata : co_hold_reg;

endmodule

// File: tb/tb_bitcoin_host_ctrl.sv
// Self-checking bench for bitcoin_host_ctrl with a stub co-processor.
module tb_bitcoin_host_ctrl;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;
  int   edge_n;
  logic [31:0] w;

  typedef struct {
    logic        hv;
    logic [31:0] hd;
    logic [15:0] addr;
    logic        e_ready;
    logic        e_busy;
    logic        e_start;
    logic [31:0] e_cycles;
    logic [31:0] e_mrd;
  } vec_t;

  vec_t tbl [24];

  bitcoin_host_ctrl_if bus();

  bitcoin_host_ctrl #(
    .HDR_WORDS(19), .NUM_NONCES(16), .MSG_ADDR(0), .OUT_ADDR(1000), .DEPTH(16384)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [31:0] rotl1(input logic [31:0] x);
    return {x[30:0], x[31]};
  endfunction

  function automatic vec_t mk(input logic hv, input logic [31:0] hd, input logic [15:0] addr,
                              input logic er, input logic eb, input logic es,
                              input logic [31:0] ec, input logic [31:0] em);
    vec_t v;
    v.hv = hv; v.hd = hd; v.addr = addr;
    v.e_ready = er; v.e_busy = eb; v.e_start = es; v.e_cycles = ec; v.e_mrd = em;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Streams 19 header words (seed, then rotl-1 each) and steps through START.
  task automatic load_header(input logic [31:0] seed);
    logic [31:0] hw;
    hw = seed;
    for (int k = 0; k < 19; k++) begin
      bus.hdr_valid = 1'b1;
      bus.hdr_data  = hw;
      chk("ld_ready", bus.hdr_ready, 1);
      tick();
      hw = rotl1(hw);
    end
    bus.hdr_valid = 1'b0;
    chk("ld_start_a", bus.start, 1);
    tick();
    chk("ld_start_b", bus.start, 1);
    tick();
    chk("ld_start_off", bus.start, 0);
    chk("ld_busy", bus.busy, 1);
  endtask

  // Collects 16 results; with stall set, res_ready follows 1,0,0,1,0,0...
  task automatic collect(input bit stall, input logic [31:0] base, input int exp_ticks);
    int k;
    int c;
    bit pend;
    logic [31:0] held;
    logic rdy;
    k = 0; c = 0; pend = 1'b0; held = '0;
    while (k < 16 && c < 200) begin
      rdy = stall ? (c % 3 == 0) : 1'b1;
      bus.res_ready = rdy;
      if (pend) begin
        chk("stall_valid", bus.res_valid, 1);
        chk("stall_hold", bus.res_data, held);
      end
      pend = 1'b0;
      if (bus.res_valid) begin
        chk("res_data", bus.res_data, base + 32'(k));
        chk("res_last", bus.res_last, (k == 15));
        if (rdy) begin
          k++;
        end else begin
          pend = 1'b1;
          held = bus.res_data;
        end
      end
      tick();
      c++;
    end
    bus.res_ready = 1'b0;
    chk("res_count", k, 16);
    chk("res_ticks", c, exp_ticks);
    chk("end_busy", bus.busy, 0);
    chk("end_valid", bus.res_valid, 0);
    chk("end_ready", bus.hdr_ready, 1);
  endtask

  initial begin
    bus.hdr_valid = 1'b0; bus.hdr_data = '0; bus.res_ready = 1'b0; bus.done = 1'b0;
    bus.mem_we = 1'b0; bus.mem_addr = '0; bus.mem_write_data = '0;

    // Job 1 header load, START pulse and first stub reads, one record per cycle.
    w = 32'h01234567;
    for (int k = 0; k < 19; k++) begin
      tbl[k] = mk(1'b1, w, 16'd0, 1'b1, (k > 0), 1'b0, 32'd0, 32'd0);
      w = rotl1(w);
    end
    tbl[19] = mk(1'b0, 32'd0, 16'd0, 1'b0, 1'b1, 1'b1, 32'd0, 32'd0);
    tbl[20] = mk(1'b0, 32'd0, 16'd0, 1'b0, 1'b1, 1'b1, 32'd1, 32'd0);
    tbl[21] = mk(1'b0, 32'd0, 16'd1, 1'b0, 1'b1, 1'b0, 32'd2, 32'd0);
    tbl[22] = mk(1'b0, 32'd0, 16'd5, 1'b0, 1'b1, 1'b0, 32'd3, 32'h02468ACE);
    tbl[23] = mk(1'b0, 32'd0, 16'd0, 1'b0, 1'b1, 1'b0, 32'd4, 32'h2468ACE0);

    // Reset state
    repeat (3) tick();
    chk("rst_hdr_ready", bus.hdr_ready, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_start", bus.start, 0);
    chk("rst_res_valid", bus.res_valid, 0);
    chk("rst_res_last", bus.res_last, 0);
    chk("rst_res_data", bus.res_data, 0);
    chk("rst_cycles", bus.cycles, 0);
    chk("rst_mrd", bus.mem_read_data, 0);
    reset_n = 1'b1;
    tick();
    chk("rel_hdr_ready", bus.hdr_ready, 1);
    chk("rel_busy", bus.busy, 0);
    chk("message_addr", bus.message_addr, 0);
    chk("output_addr", bus.output_addr, 1000);

    for (int v = 0; v < 24; v++) begin
      bus.hdr_valid = tbl[v].hv;
      bus.hdr_data  = tbl[v].hd;
      bus.mem_we    = 1'b0;
      bus.mem_addr  = tbl[v].addr;
      chk("tbl_hdr_ready", bus.hdr_ready, tbl[v].e_ready);
      chk("tbl_busy", bus.busy, tbl[v].e_busy);
      chk("tbl_start", bus.start, tbl[v].e_start);
      chk("tbl_cycles", bus.cycles, tbl[v].e_cycles);
      chk("tbl_mrd", bus.mem_read_data, tbl[v].e_mrd);
      tick();
    end
    edge_n = 5;

    // Job 1 run: results, wrapped write, done at the 100th counted edge
    for (int i = 0; i < 16; i++) begin
      bus.mem_we = 1'b1;
      bus.mem_addr = 16'(1000 + i);
      bus.mem_write_data = 32'hA5000000 + 32'(i);
      tick();
      edge_n++;
    end
    bus.mem_addr = 16'd16387;
    bus.mem_write_data = 32'hDEADBEEF;
    tick(); edge_n++;
    bus.mem_we = 1'b0;
    bus.mem_addr = 16'd3;
    tick(); edge_n++;
    chk("wrap_rd", bus.mem_read_data, 32'hDEADBEEF);
    bus.mem_addr = 16'd1000;
    tick(); edge_n++;
    chk("run_rd_res0", bus.mem_read_data, 32'hA5000000);
    bus.mem_addr = 16'd16387;
    while (edge_n < 99) begin
      tick();
      edge_n++;
    end
    bus.done = 1'b1;
    tick(); edge_n++;
    chk("cycles_100", bus.cycles, 100);
    chk("rdreq_valid", bus.res_valid, 0);
    collect(1'b0, 32'hA5000000, 32);
    chk("cycles_hold", bus.cycles, 100);
    chk("mrd_after_job", bus.mem_read_data, 32'hDEADBEEF);
    repeat (3) tick();
    chk("done_held_idle", bus.busy, 0);
    bus.done = 1'b0;

    // Stray co-processor accesses while IDLE
    bus.mem_we = 1'b1;
    bus.mem_addr = 16'd1000;
    bus.mem_write_data = 32'hBAD0BAD0;
    tick();
    bus.mem_we = 1'b0;
    bus.mem_addr = 16'd3;
    tick();
    chk("idle_mrd_hold", bus.mem_read_data, 32'hDEADBEEF);

    // Job 2: backpressure on the result stream
    load_header(32'h0F0F1234);
    bus.mem_addr = 16'd1000;
    tick();
    chk("stray_ignored", bus.mem_read_data, 32'hA5000000);
    for (int i = 0; i < 16; i++) begin
      bus.mem_we = 1'b1;
      bus.mem_addr = 16'(1000 + i);
      bus.mem_write_data = 32'h5A000000 + 32'(i);
      tick();
    end
    bus.mem_we = 1'b0;
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
    collect(1'b1, 32'h5A000000, 49);

    // Job 3: reset asserted mid-clock during RUN
    load_header(32'h13579BDF);
    bus.mem_addr = 16'd1;
    tick();
    chk("j3_rd", bus.mem_read_data, rotl1(32'h13579BDF));
    tick();
    #2;
    reset_n = 1'b0;
    #1;
    chk("midrst_start", bus.start, 0);
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_hdr_ready", bus.hdr_ready, 0);
    chk("midrst_cycles", bus.cycles, 0);
    chk("midrst_mrd", bus.mem_read_data, 0);
    chk("midrst_res_valid", bus.res_valid, 0);
    tick();
    reset_n = 1'b1;
    tick();
    chk("rerel_hdr_ready", bus.hdr_ready, 1);
    chk("rerel_busy", bus.busy, 0);

    // Job 4: RAM contents survive the reset
    load_header(32'hCAFEF00D);
    bus.mem_addr = 16'd1;
    tick();
    chk("j4_hdr1", bus.mem_read_data, 32'h95FDE01B);
    w = 32'hCAFEF00D;
    for (int k = 0; k < 18; k++) w = rotl1(w);
    bus.mem_addr = 16'd18;
    tick();
    chk("j4_hdr18", bus.mem_read_data, w);
    bus.mem_addr = 16'd1001;
    tick();
    chk("j4_keep_res", bus.mem_read_data, 32'h5A000001);
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
    collect(1'b0, 32'h5A000000, 32);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
